// File: rtl/register_file_mp_if.sv
// Bundle of register-file signals shared by issue/writeback (master) and the file (slave).
// Read data/busy are combinational; writes and reserves take effect at the next clock edge.
// No backpressure: every write and reserve presented is accepted.
interface register_file_mp_if #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_READ       = 2,
  parameter int NUM_WRITE      = 2
);
  logic [NUM_WRITE-1:0]                write_en;
  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] regw;
  logic [NUM_WRITE*DATA_WIDTH-1:0]     dataw;
  logic [NUM_READ*REG_ADDR_WIDTH-1:0]  reg_rd;
  logic [NUM_READ*DATA_WIDTH-1:0]      data_rd;
  logic [NUM_READ-1:0]                 busy_rd;
  logic                                reserve_en;
  logic [REG_ADDR_WIDTH-1:0]           reserve_addr;
  logic                                any_busy;

  modport master (
    output write_en, regw, dataw, reg_rd, reserve_en, reserve_addr,
    input  data_rd, busy_rd, any_busy
  );

  modport slave (
    input  write_en, regw, dataw, reg_rd, reserve_en, reserve_addr,
    output data_rd, busy_rd, any_busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-ported register file with optional write-to-read bypass and per-register busy scoreboard.
// Latency: reads 0 cycles (combinational), writes and reserves visible 1 cycle after the edge.
// No backpressure: all ports accept every cycle; r0 reads zero and is never busy.
module register_file_mp #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_READ       = 2,
  parameter int NUM_WRITE      = 2,
  parameter int BYPASS         = 1
) (
  input logic               clk,
  input logic               rst_n,
  register_file_mp_if.slave rf
);
  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  // Packed views of the flattened port buses.
  logic [NUM_WRITE-1:0][REG_ADDR_WIDTH-1:0] waddr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]     wdata;
  logic [NUM_READ-1:0][REG_ADDR_WIDTH-1:0]  raddr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]      rd_dat;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]      rd_byp;
  logic [NUM_READ-1:0]                      rd_hit;
  logic [NUM_READ-1:0]                      rd_busy;

  assign waddr = rf.regw;
  assign wdata = rf.dataw;
  assign raddr = rf.reg_rd;

  // Next state: writes applied in ascending port order so the highest port wins;
  // a reserve is applied last so a newly issued producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (rf.write_en[k] && (waddr[k] != '0)) begin
        regs_d[waddr[k]] = wdata[k];
        busy_d[waddr[k]] = 1'b0;
      end
    end
    if (rf.reserve_en && (rf.reserve_addr != '0)) begin
      busy_d[rf.reserve_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Storage and scoreboard; reset discards data and pending reservations at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: r0 is zero; a same-cycle write (when bypassing) supplies data and masks busy.
  // Bypass is gated by rst_n so nothing leaks through while the file is held in reset.
  always_comb begin
    rd_dat  = '0;
    rd_byp  = '0;
    rd_hit  = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if ((BYPASS != 0) && rst_n && (raddr[p] != '0)) begin
        for (int k = 0; k < NUM_WRITE; k++) begin
          if (rf.write_en[k] && (waddr[k] == raddr[p])) begin
            rd_hit[p] = 1'b1;
            rd_byp[p] = wdata[k];
          end
        end
      end
      if (raddr[p] == '0) begin
        rd_dat[p] = '0;
      end else if (rd_hit[p]) begin
        rd_dat[p] = rd_byp[p];
      end else begin
        rd_dat[p] = regs_q[raddr[p]];
      end
      rd_busy[p] = busy_q[raddr[p]] & ~rd_hit[p];
    end
  end

  assign rf.data_rd  = rd_dat;
  assign rf.busy_rd  = rd_busy;
  assign rf.any_busy = |busy_q[NUM_REGS-1:1];

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: one bypassing and one non-bypassing instance driven in lockstep.
// Expected read results are queued when stimulus is applied and compared when sampled.
// Inputs change just after the falling edge; outputs are sampled 1-2 ns later, away from rising edges.
module tb_register_file_mp;
  logic        clk;
  logic        rst_n;
  logic [1:0]  write_en;
  logic [7:0]  regw;
  logic [15:0] dataw;
  logic [7:0]  reg_rd;
  logic        reserve_en;
  logic [3:0]  reserve_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          bp;
    int          port;
    logic [7:0]  data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  register_file_mp_if #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_READ(2), .NUM_WRITE(2)) ifb ();
  register_file_mp_if #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_READ(2), .NUM_WRITE(2)) ifn ();

  assign ifb.write_en = write_en;      assign ifn.write_en = write_en;
  assign ifb.regw = regw;              assign ifn.regw = regw;
  assign ifb.dataw = dataw;            assign ifn.dataw = dataw;
  assign ifb.reg_rd = reg_rd;          assign ifn.reg_rd = reg_rd;
  assign ifb.reserve_en = reserve_en;  assign ifn.reserve_en = reserve_en;
  assign ifb.reserve_addr = reserve_addr;
  assign ifn.reserve_addr = reserve_addr;

  register_file_mp #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1))
    u_byp (.clk(clk), .rst_n(rst_n), .rf(ifb));
  register_file_mp #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0))
    u_nbp (.clk(clk), .rst_n(rst_n), .rf(ifn));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rd_d(bit bp, int p);
    return bp ? ifb.data_rd[p*8 +: 8] : ifn.data_rd[p*8 +: 8];
  endfunction

  function automatic logic rd_b(bit bp, int p);
    return bp ? ifb.busy_rd[p] : ifn.busy_rd[p];
  endfunction

  task automatic clr();
    write_en = '0; regw = '0; dataw = '0; reserve_en = 1'b0; reserve_addr = '0;
  endtask

  task automatic wr(int k, logic [3:0] a, logic [7:0] d);
    write_en[k] = 1'b1; regw[k*4 +: 4] = a; dataw[k*8 +: 8] = d;
  endtask

  task automatic rd(int p, logic [3:0] a);
    reg_rd[p*4 +: 4] = a;
  endtask

  task automatic push(bit bp, int p, logic [7:0] d, logic b, string n);
    exp_t x;
    x.bp = bp; x.port = p; x.data = d; x.busy = b; x.name = n;
    sb.push_back(x);
  endtask

  task automatic push_both(int p, logic [7:0] d, logic b, string n);
    push(1'b1, p, d, b, n);
    push(1'b0, p, d, b, n);
  endtask

  task automatic test_reset();
    clr(); rd(0, 4'd1); rd(1, 4'd15);
    #2;
    push_both(0, 8'h00, 1'b0, "reset_r1"); push_both(1, 8'h00, 1'b0, "reset_r15");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b0 || ifn.any_busy !== 1'b0) begin fails++;
      $display("FAIL reset_any_busy: got %b/%b want 0", ifb.any_busy, ifn.any_busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    push_both(0, 8'h00, 1'b0, "idle_r1"); push_both(1, 8'h00, 1'b0, "idle_r15");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    // write r3 and reserve r2, then pull reset between edges
    wr(0, 4'd3, 8'h5A); reserve_en = 1'b1; reserve_addr = 4'd2;
    @(negedge clk); clr(); rd(0, 4'd3); rd(1, 4'd2); #1;
    push_both(0, 8'h5A, 1'b0, "pre_rst_r3"); push_both(1, 8'h00, 1'b1, "pre_rst_r2");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    rst_n = 1'b0; #1;
    push_both(0, 8'h00, 1'b0, "mid_rst_r3"); push_both(1, 8'h00, 1'b0, "mid_rst_r2");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b0 || ifn.any_busy !== 1'b0) begin fails++;
      $display("FAIL mid_rst_any_busy: got %b/%b want 0", ifb.any_busy, ifn.any_busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write_conflict();
    @(negedge clk); clr();
    wr(0, 4'd5, 8'h11); wr(1, 4'd5, 8'h22); rd(0, 4'd5); rd(1, 4'd5); #1;
    push(1'b1, 0, 8'h22, 1'b0, "conflict_byp_p0"); push(1'b1, 1, 8'h22, 1'b0, "conflict_byp_p1");
    push(1'b0, 0, 8'h00, 1'b0, "conflict_nbp_p0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(0, 8'h22, 1'b0, "conflict_stored");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk); clr(); wr(0, 4'd7, 8'h3C);
    @(negedge clk); clr(); wr(1, 4'd7, 8'hA5); rd(0, 4'd7); #1;
    push(1'b0, 0, 8'h3C, 1'b0, "nbp_old_value"); push(1'b1, 0, 8'hA5, 1'b0, "byp_new_value");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(0, 8'hA5, 1'b0, "r7_after_write");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
  endtask

  task automatic test_reg0();
    @(negedge clk); clr();
    wr(0, 4'd0, 8'hFF); wr(1, 4'd0, 8'hFF); reserve_en = 1'b1; reserve_addr = 4'd0;
    rd(0, 4'd0); rd(1, 4'd0); #1;
    push_both(0, 8'h00, 1'b0, "r0_same_p0"); push_both(1, 8'h00, 1'b0, "r0_same_p1");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(0, 8'h00, 1'b0, "r0_next_p0"); push_both(1, 8'h00, 1'b0, "r0_next_p1");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b0 || ifn.any_busy !== 1'b0) begin fails++;
      $display("FAIL r0_any_busy: got %b/%b want 0", ifb.any_busy, ifn.any_busy); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); clr(); reserve_en = 1'b1; reserve_addr = 4'd4; rd(1, 4'd4); #1;
    push_both(1, 8'h00, 1'b0, "sb_reserve_cycle");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(1, 8'h00, 1'b1, "sb_busy_set");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b1 || ifn.any_busy !== 1'b1) begin fails++;
      $display("FAIL sb_any_busy_set: got %b/%b want 1", ifb.any_busy, ifn.any_busy); end
    wr(0, 4'd4, 8'h77); #1;
    push(1'b1, 1, 8'h77, 1'b0, "sb_write_byp"); push(1'b0, 1, 8'h00, 1'b1, "sb_write_nbp");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(1, 8'h77, 1'b0, "sb_cleared");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b0 || ifn.any_busy !== 1'b0) begin fails++;
      $display("FAIL sb_any_busy_clear: got %b/%b want 0", ifb.any_busy, ifn.any_busy); end
  endtask

  task automatic test_reserve_and_write();
    @(negedge clk); clr(); reserve_en = 1'b1; reserve_addr = 4'd9; wr(1, 4'd9, 8'h10); rd(0, 4'd9); #1;
    push(1'b1, 0, 8'h10, 1'b0, "rw_same_byp"); push(1'b0, 0, 8'h00, 1'b0, "rw_same_nbp");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(0, 8'h10, 1'b1, "rw_reserve_wins");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b1 || ifn.any_busy !== 1'b1) begin fails++;
      $display("FAIL rw_any_busy: got %b/%b want 1", ifb.any_busy, ifn.any_busy); end
    wr(0, 4'd9, 8'h20); #1;
    push(1'b1, 0, 8'h20, 1'b0, "rw_second_byp"); push(1'b0, 0, 8'h10, 1'b1, "rw_second_nbp");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    @(negedge clk); clr(); #1;
    push_both(0, 8'h20, 1'b0, "rw_cleared");
    while (sb.size() > 0) begin
      e = sb.pop_front(); tests++;
      if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
        $display("FAIL %s bp=%0d p%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
    end
    tests++;
    if (ifb.any_busy !== 1'b0 || ifn.any_busy !== 1'b0) begin fails++;
      $display("FAIL rw_any_busy_clear: got %b/%b want 0", ifb.any_busy, ifn.any_busy); end
  endtask

  // Random back-to-back writes and reads against a reference memory.
  task automatic test_back_to_back();
    logic [7:0] mem [16];
    logic [3:0] a;
    logic [7:0] bpv;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    @(negedge clk); clr(); rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk); clr();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) != 0) wr(k, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      for (int p = 0; p < 2; p++) rd(p, 4'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < 2; p++) begin
        a = reg_rd[p*4 +: 4];
        bpv = (a == 4'd0) ? 8'h00 : mem[a];
        for (int k = 0; k < 2; k++) begin
          if (a != 4'd0 && write_en[k] && regw[k*4 +: 4] == a) bpv = dataw[k*8 +: 8];
        end
        push(1'b0, p, (a == 4'd0) ? 8'h00 : mem[a], 1'b0, "b2b_nbp");
        push(1'b1, p, bpv, 1'b0, "b2b_byp");
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); tests++;
        if ({rd_d(e.bp, e.port), rd_b(e.bp, e.port)} !== {e.data, e.busy}) begin fails++;
          $display("FAIL %s bp=%0d p%0d it=%0d: got %h/%b want %h/%b", e.name, e.bp, e.port, it, rd_d(e.bp, e.port), rd_b(e.bp, e.port), e.data, e.busy); end
      end
      for (int k = 0; k < 2; k++) begin
        if (write_en[k] && regw[k*4 +: 4] != 4'd0) mem[regw[k*4 +: 4]] = dataw[k*8 +: 8];
      end
    end
    @(negedge clk); clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    reg_rd = '0;
    test_reset();
    test_write_conflict();
    test_no_bypass();
    test_reg0();
    test_scoreboard();
    test_reserve_and_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
